// File: rtl/axi_apb_pkg.sv
// Shared constants for the AXI-Lite to APB bridge: FSM state encoding,
// AXI response codes and a helper for the slave-index width.
package axi_apb_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETUP  = 3'd1;
  localparam logic [2:0] S_ACCESS = 3'd2;
  localparam logic [2:0] S_WRESP  = 3'd3;
  localparam logic [2:0] S_RRESP  = 3'd4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Width of the slave index; a single slave still gets a 1-bit index.
  function automatic int slv_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axil_apb_bridge_ms_if.sv
// Bus bundle for the bridge: AXI-Lite channels plus the multi-slave APB side.
// modport slave  = the bridge (AXI-Lite slave, APB master).
// modport master = the system around it (AXI-Lite master, APB slaves).
interface axil_apb_bridge_ms_if #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int APB_ADDR_W = 16,
  parameter int NUM_SLV    = 4
);
  localparam int STRB_W = DATA_W / 8;

  logic [ADDR_W-1:0]         AWADDR;
  logic                      AWVALID;
  logic                      AWREADY;
  logic [DATA_W-1:0]         WDATA;
  logic [STRB_W-1:0]         WSTRB;
  logic                      WVALID;
  logic                      WREADY;
  logic [1:0]                BRESP;
  logic                      BVALID;
  logic                      BREADY;
  logic [ADDR_W-1:0]         ARADDR;
  logic                      ARVALID;
  logic                      ARREADY;
  logic [DATA_W-1:0]         RDATA;
  logic [1:0]                RRESP;
  logic                      RVALID;
  logic                      RREADY;

  logic [APB_ADDR_W-1:0]     PADDR;
  logic [NUM_SLV-1:0]        PSEL;
  logic                      PENABLE;
  logic                      PWRITE;
  logic [DATA_W-1:0]         PWDATA;
  logic [STRB_W-1:0]         PSTRB;
  logic [NUM_SLV*DATA_W-1:0] PRDATA;
  logic [NUM_SLV-1:0]        PREADY;
  logic [NUM_SLV-1:0]        PSLVERR;

  modport slave (
    input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    input  PRDATA, PREADY, PSLVERR,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID,
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB
  );

  modport master (
    output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    output PRDATA, PREADY, PSLVERR,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID,
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB
  );

endinterface

// File: rtl/apb_tout_cnt.sv
// ACCESS-phase timeout counter: counts cycles while start_i is high and
// flags the cycle that is the TOUT_CYC-th one; clear_i returns it to zero.
module apb_tout_cnt #(
  parameter int TOUT_CYC = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  input  logic clear_i,
  output logic expire_o
);

  logic [7:0] cnt_q;

  // Cycle counter, held at zero outside the ACCESS phase.
  // NOTE: state registers use non-blocking (<=) so every flop samples the pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (start_i) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  assign expire_o = start_i && (cnt_q == 8'(TOUT_CYC - 1));

endmodule

// File: rtl/axil_apb_bridge_ms.sv
// AXI-Lite slave to multi-slave APB master bridge. One-entry AW/W/AR buffers,
// alternating read/write priority, address decode with DECERR, ACCESS timeout.
module axil_apb_bridge_ms
  import axi_apb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int APB_ADDR_W = 16,
  parameter int NUM_SLV    = 4,
  parameter int TOUT_CYC   = 16
) (
  input logic                 ACLK,
  input logic                 ARESETn,
  axil_apb_bridge_ms_if.slave bus
);

  localparam int STRB_W  = DATA_W / 8;
  localparam int SLV_W   = slv_w(NUM_SLV);
  localparam int DEC_W   = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 0;
  localparam int TOP_LSB = APB_ADDR_W + DEC_W;

  // Any address bit above the slave-index field means no slave is mapped there.
  function automatic logic addr_decerr(input logic [ADDR_W-1:0] a);
    return |(a >> TOP_LSB);
  endfunction

  function automatic logic [SLV_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
    return SLV_W'(a >> APB_ADDR_W) & SLV_W'(NUM_SLV - 1);
  endfunction

  logic [2:0]            state_q, state_d;
  logic                  aw_full_q, aw_full_d, w_full_q, w_full_d, ar_full_q, ar_full_d;
  logic [ADDR_W-1:0]     aw_addr_q, aw_addr_d, ar_addr_q, ar_addr_d;
  logic [DATA_W-1:0]     w_data_q, w_data_d;
  logic [STRB_W-1:0]     w_strb_q, w_strb_d;
  logic                  awready_q, awready_d, wready_q, wready_d, arready_q, arready_d;
  logic                  last_rd_q, last_rd_d, is_wr_q, is_wr_d;
  logic [SLV_W-1:0]      idx_q, idx_d;
  logic [NUM_SLV-1:0]    psel_q, psel_d;
  logic                  penable_q, penable_d, pwrite_q, pwrite_d;
  logic [APB_ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0]     pwdata_q, pwdata_d;
  logic [STRB_W-1:0]     pstrb_q, pstrb_d;
  logic                  bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [1:0]            bresp_q, bresp_d, rresp_q, rresp_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;

  logic                  aw_fire, w_fire, ar_fire, wr_pend, rd_pend, gnt_rd, gnt_wr;
  logic [ADDR_W-1:0]     aw_addr_eff, ar_addr_eff, gnt_addr;
  logic [DATA_W-1:0]     w_data_eff, prdata_sel;
  logic [STRB_W-1:0]     w_strb_eff;
  logic                  pready_sel, pslverr_sel, tout_exp, in_access;
  logic [1:0]            xfer_resp;

  // A beat arriving this cycle counts as pending so the transfer starts on the accept edge.
  assign aw_fire     = bus.AWVALID && awready_q;
  assign w_fire      = bus.WVALID && wready_q;
  assign ar_fire     = bus.ARVALID && arready_q;
  assign aw_addr_eff = aw_full_q ? aw_addr_q : bus.AWADDR;
  assign ar_addr_eff = ar_full_q ? ar_addr_q : bus.ARADDR;
  assign w_data_eff  = w_full_q ? w_data_q : bus.WDATA;
  assign w_strb_eff  = w_full_q ? w_strb_q : bus.WSTRB;
  assign wr_pend     = (aw_full_q || aw_fire) && (w_full_q || w_fire);
  assign rd_pend     = ar_full_q || ar_fire;
  assign gnt_rd      = rd_pend && (!wr_pend || !last_rd_q);
  assign gnt_wr      = wr_pend && !gnt_rd;
  assign gnt_addr    = gnt_rd ? ar_addr_eff : aw_addr_eff;

  // Only the selected slave's response lines are looked at.
  assign pready_sel  = bus.PREADY[idx_q];
  assign pslverr_sel = bus.PSLVERR[idx_q];
  assign prdata_sel  = bus.PRDATA[idx_q*DATA_W +: DATA_W];
  assign xfer_resp   = (pready_sel && !pslverr_sel) ? RESP_OKAY : RESP_SLVERR;
  assign in_access   = (state_q == S_ACCESS);

  apb_tout_cnt #(.TOUT_CYC(TOUT_CYC)) u_tout (
    .clk      (ACLK),
    .rst_n    (ARESETn),
    .start_i  (in_access),
    .clear_i  (!in_access),
    .expire_o (tout_exp)
  );

  // Next-state logic for buffers, FSM, APB request and AXI responses.
  always_comb begin
    // NOTE: every _d gets a default first so no path leaves it unassigned (no latches).
    state_d   = state_q;   aw_full_d = aw_full_q; w_full_d  = w_full_q;  ar_full_d = ar_full_q;
    aw_addr_d = aw_addr_q; ar_addr_d = ar_addr_q; w_data_d  = w_data_q;  w_strb_d  = w_strb_q;
    last_rd_d = last_rd_q; is_wr_d   = is_wr_q;   idx_d     = idx_q;     psel_d    = psel_q;
    penable_d = penable_q; pwrite_d  = pwrite_q;  paddr_d   = paddr_q;   pwdata_d  = pwdata_q;
    pstrb_d   = pstrb_q;   bvalid_d  = bvalid_q;  bresp_d   = bresp_q;   rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;   rdata_d   = rdata_q;

    if (aw_fire) begin aw_full_d = 1'b1; aw_addr_d = bus.AWADDR; end
    if (w_fire)  begin w_full_d = 1'b1; w_data_d = bus.WDATA; w_strb_d = bus.WSTRB; end
    if (ar_fire) begin ar_full_d = 1'b1; ar_addr_d = bus.ARADDR; end

    case (state_q)
      S_IDLE: begin
        if (gnt_rd || gnt_wr) begin
          last_rd_d = gnt_rd;
          is_wr_d   = gnt_wr;
          if (addr_decerr(gnt_addr)) begin
            if (gnt_wr) begin
              state_d = S_WRESP; bvalid_d = 1'b1; bresp_d = RESP_DECERR;
            end else begin
              state_d = S_RRESP; rvalid_d = 1'b1; rresp_d = RESP_DECERR; rdata_d = '0;
            end
          end else begin
            state_d   = S_SETUP;
            idx_d     = addr_idx(gnt_addr);
            psel_d    = NUM_SLV'(1) << addr_idx(gnt_addr);
            penable_d = 1'b0;
            pwrite_d  = gnt_wr;
            paddr_d   = gnt_addr[APB_ADDR_W-1:0];
            pwdata_d  = gnt_wr ? w_data_eff : '0;
            pstrb_d   = gnt_wr ? w_strb_eff : '0;
          end
        end
      end
      S_SETUP: begin
        penable_d = 1'b1;
        state_d   = S_ACCESS;
      end
      S_ACCESS: begin
        if (pready_sel || tout_exp) begin
          psel_d    = '0;
          penable_d = 1'b0;
          if (is_wr_q) begin
            state_d = S_WRESP; bvalid_d = 1'b1; bresp_d = xfer_resp;
          end else begin
            state_d = S_RRESP; rvalid_d = 1'b1; rresp_d = xfer_resp;
            rdata_d = pready_sel ? prdata_sel : '0;
          end
        end
      end
      S_WRESP: begin
        if (bus.BREADY) begin
          bvalid_d = 1'b0; aw_full_d = 1'b0; w_full_d = 1'b0; state_d = S_IDLE;
        end
      end
      S_RRESP: begin
        if (bus.RREADY) begin
          rvalid_d = 1'b0; ar_full_d = 1'b0; state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    awready_d = !aw_full_d && (state_d == S_IDLE);
    wready_d  = !w_full_d && (state_d == S_IDLE);
    arready_d = !ar_full_d && (state_d == S_IDLE);
  end

  // State registers; reset clears everything including buffer contents.
  // NOTE: the small buffer data registers are reset so outputs read 0 after reset; a RAM would not be.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q   <= S_IDLE; aw_full_q <= 1'b0; w_full_q  <= 1'b0; ar_full_q <= 1'b0;
      aw_addr_q <= '0;     ar_addr_q <= '0;   w_data_q  <= '0;   w_strb_q  <= '0;
      awready_q <= 1'b0;   wready_q  <= 1'b0; arready_q <= 1'b0;
      last_rd_q <= 1'b0;   is_wr_q   <= 1'b0; idx_q     <= '0;   psel_q    <= '0;
      penable_q <= 1'b0;   pwrite_q  <= 1'b0; paddr_q   <= '0;   pwdata_q  <= '0;
      pstrb_q   <= '0;     bvalid_q  <= 1'b0; bresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;   rresp_q   <= RESP_OKAY;               rdata_q   <= '0;
    end else begin
      state_q   <= state_d;   aw_full_q <= aw_full_d; w_full_q  <= w_full_d;  ar_full_q <= ar_full_d;
      aw_addr_q <= aw_addr_d; ar_addr_q <= ar_addr_d; w_data_q  <= w_data_d;  w_strb_q  <= w_strb_d;
      awready_q <= awready_d; wready_q  <= wready_d;  arready_q <= arready_d;
      last_rd_q <= last_rd_d; is_wr_q   <= is_wr_d;   idx_q     <= idx_d;     psel_q    <= psel_d;
      penable_q <= penable_d; pwrite_q  <= pwrite_d;  paddr_q   <= paddr_d;   pwdata_q  <= pwdata_d;
      pstrb_q   <= pstrb_d;   bvalid_q  <= bvalid_d;  bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;  rresp_q   <= rresp_d;   rdata_q   <= rdata_d;
    end
  end

  assign bus.AWREADY = awready_q;
  assign bus.WREADY  = wready_q;
  assign bus.ARREADY = arready_q;
  assign bus.BVALID  = bvalid_q;
  assign bus.BRESP   = bresp_q;
  assign bus.RVALID  = rvalid_q;
  assign bus.RRESP   = rresp_q;
  assign bus.RDATA   = rdata_q;
  assign bus.PSEL    = psel_q;
  assign bus.PENABLE = penable_q;
  assign bus.PWRITE  = pwrite_q;
  assign bus.PADDR   = paddr_q;
  assign bus.PWDATA  = pwdata_q;
  assign bus.PSTRB   = pstrb_q;

endmodule

// File: tb/tb_axil_apb_bridge_ms.sv
// Directed bench for axil_apb_bridge_ms: latency, ordering, wait states,
// timeout, decode errors, async reset and read/write arbitration.
module tb_axil_apb_bridge_ms;
  import axi_apb_pkg::*;

  localparam int ADDR_W = 32, DATA_W = 32, APB_ADDR_W = 16, NUM_SLV = 4, TOUT_CYC = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  axil_apb_bridge_ms_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .APB_ADDR_W(APB_ADDR_W),
                          .NUM_SLV(NUM_SLV)) bus ();

  axil_apb_bridge_ms #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .APB_ADDR_W(APB_ADDR_W),
                       .NUM_SLV(NUM_SLV), .TOUT_CYC(TOUT_CYC)) dut (
    .ACLK    (clk),
    .ARESETn (rst_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Read helper: issue AR, wait for RVALID, return data/resp and APB select cycles.
  task automatic do_read(input logic [31:0] addr, output logic [31:0] data,
                         output logic [1:0] resp, output int sel_cycles, output bit ok);
    bus.ARADDR = addr; bus.ARVALID = 1'b1;
    ok = 1'b0; sel_cycles = 0; data = '0; resp = '0;
    for (int i = 0; i < 40 && !ok; i++) begin
      step();
      bus.ARVALID = 1'b0;
      if (bus.PSEL != '0) sel_cycles++;
      if (bus.RVALID) begin ok = 1'b1; data = bus.RDATA; resp = bus.RRESP; end
    end
    bus.RREADY = 1'b1;
    step();
    bus.RREADY = 1'b0;
  endtask

  // Arbitration log: one entry per APB SETUP phase.
  logic        seq_wr   [8];
  logic [15:0] seq_addr [8];
  int          seq_n = 0;

  task automatic run_until_idle(input string tag, input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      step();
      bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.ARVALID = 1'b0;
      if (bus.PSEL != '0 && !bus.PENABLE && seq_n < 8) begin
        seq_wr[seq_n] = bus.PWRITE; seq_addr[seq_n] = bus.PADDR; seq_n++;
      end
      if (bus.AWREADY && bus.WREADY && bus.ARREADY) done = 1'b1;
    end
    check({tag, "_idle"}, 64'(done), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd_data;
    logic [1:0]  rd_resp;
    int          sel_cyc, acc, n_setup;
    bit          ok, flag;

    rst_n = 1'b0;
    bus.AWADDR = '0; bus.AWVALID = 1'b0; bus.WDATA = '0; bus.WSTRB = '0; bus.WVALID = 1'b0;
    bus.BREADY = 1'b0; bus.ARADDR = '0; bus.ARVALID = 1'b0; bus.RREADY = 1'b0;
    bus.PRDATA = '0; bus.PREADY = '0; bus.PSLVERR = '0;

    // Reset state and ready rise one edge after release.
    step(); step();
    check("rst_awready", 64'(bus.AWREADY), 64'd0);
    check("rst_psel",    64'(bus.PSEL),    64'd0);
    check("rst_valids",  64'({bus.BVALID, bus.RVALID}), 64'd0);
    check("rst_resp",    64'({bus.BRESP, bus.RRESP}),   64'd0);
    rst_n = 1'b1;
    step();
    check("rel_readies", 64'({bus.AWREADY, bus.WREADY, bus.ARREADY}), 64'b111);

    // Zero-wait write to slave 1; other slaves report errors that must be ignored.
    bus.PREADY = 4'b1111; bus.PSLVERR = 4'b1101;
    bus.AWADDR = 32'h0001_0010; bus.AWVALID = 1'b1;
    bus.WDATA = 32'hDEAD_BEEF; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
    step();
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    check("wr1_setup_psel",    64'(bus.PSEL),    64'b0010);
    check("wr1_setup_penable", 64'(bus.PENABLE), 64'd0);
    check("wr1_paddr",         64'(bus.PADDR),   64'h0010);
    check("wr1_pwrite",        64'(bus.PWRITE),  64'd1);
    check("wr1_pwdata",        64'(bus.PWDATA),  64'hDEAD_BEEF);
    check("wr1_pstrb",         64'(bus.PSTRB),   64'hF);
    check("wr1_awready_busy",  64'(bus.AWREADY), 64'd0);
    step();
    check("wr1_access", 64'({bus.PSEL, bus.PENABLE}), 64'b0010_1);
    check("wr1_access_bvalid", 64'(bus.BVALID), 64'd0);
    step();
    check("wr1_bvalid_c3", 64'(bus.BVALID), 64'd1);
    check("wr1_bresp",     64'(bus.BRESP),  64'(RESP_OKAY));
    check("wr1_psel_off",  64'(bus.PSEL),   64'd0);
    bus.BREADY = 1'b1;
    step();
    bus.BREADY = 1'b0;
    check("wr1_bvalid_done", 64'(bus.BVALID),  64'd0);
    check("wr1_awready_back", 64'(bus.AWREADY), 64'd1);
    bus.PSLVERR = '0;

    // W arrives three cycles before AW, slave 0.
    bus.WDATA = 32'hCAFE_F00D; bus.WSTRB = 4'h3; bus.WVALID = 1'b1;
    step();
    bus.WVALID = 1'b0;
    check("wfirst_wready",  64'(bus.WREADY),  64'd0);
    check("wfirst_awready", 64'(bus.AWREADY), 64'd1);
    flag = (bus.PSEL == '0);
    step(); if (bus.PSEL != '0) flag = 1'b0;
    step(); if (bus.PSEL != '0) flag = 1'b0;
    check("wfirst_no_apb", 64'(flag), 64'd1);
    bus.AWADDR = 32'h0000_0100; bus.AWVALID = 1'b1;
    step();
    bus.AWVALID = 1'b0;
    check("wfirst_psel",   64'(bus.PSEL),   64'b0001);
    check("wfirst_paddr",  64'(bus.PADDR),  64'h0100);
    check("wfirst_pwdata", 64'(bus.PWDATA), 64'hCAFE_F00D);
    check("wfirst_pstrb",  64'(bus.PSTRB),  64'h3);
    n_setup = 1; flag = !(bus.AWREADY || bus.WREADY); ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      step();
      if (bus.PSEL != '0 && !bus.PENABLE) n_setup++;
      if (bus.AWREADY || bus.WREADY) flag = 1'b0;
      if (bus.BVALID) ok = 1'b1;
    end
    check("wfirst_bvalid", 64'(ok), 64'd1);
    step(); if (bus.AWREADY || bus.WREADY || !bus.BVALID) flag = 1'b0;
    step(); if (bus.AWREADY || bus.WREADY || !bus.BVALID) flag = 1'b0;
    check("wfirst_ready_low", 64'(flag), 64'd1);
    bus.BREADY = 1'b1;
    step();
    bus.BREADY = 1'b0;
    check("wfirst_ready_back", 64'({bus.AWREADY, bus.WREADY, bus.BVALID}), 64'b110);
    check("wfirst_one_xfer",   64'(n_setup), 64'd1);

    // Read slave 2 with four wait states, RREADY held off five cycles.
    bus.PREADY = 4'b1011;
    bus.PRDATA = {32'h3333_3333, 32'h1234_5678, 32'h1111_1111, 32'h0000_0000};
    bus.ARADDR = 32'h0002_0044; bus.ARVALID = 1'b1;
    step();
    bus.ARVALID = 1'b0;
    check("rd2_setup", 64'({bus.PSEL, bus.PENABLE, bus.PWRITE}), 64'b0100_0_0);
    check("rd2_pstrb", 64'(bus.PSTRB), 64'd0);
    check("rd2_paddr", 64'(bus.PADDR), 64'h0044);
    acc = 0; ok = 1'b0; flag = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      step();
      if (bus.PSEL[2] && bus.PENABLE) begin
        acc++;
        if (bus.PADDR != 16'h0044 || bus.PWRITE) flag = 1'b0;
        if (acc == 5) bus.PREADY[2] = 1'b1;
      end
      if (bus.RVALID) ok = 1'b1;
    end
    bus.PREADY[2] = 1'b0;
    check("rd2_rvalid",      64'(ok),        64'd1);
    check("rd2_access_cyc",  64'(acc),       64'd5);
    check("rd2_addr_stable", 64'(flag),      64'd1);
    check("rd2_rdata",       64'(bus.RDATA), 64'h1234_5678);
    check("rd2_rresp",       64'(bus.RRESP), 64'(RESP_OKAY));
    flag = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (!bus.RVALID || bus.RDATA != 32'h1234_5678 || bus.RRESP != RESP_OKAY) flag = 1'b0;
    end
    check("rd2_hold_stable", 64'(flag), 64'd1);
    bus.RREADY = 1'b1;
    step();
    bus.RREADY = 1'b0;
    check("rd2_rvalid_done", 64'(bus.RVALID), 64'd0);

    // Read slave 3 that never answers: timeout after TOUT_CYC ACCESS cycles.
    bus.PREADY = 4'b0111;
    bus.PRDATA[96 +: 32] = 32'hFFFF_0000;
    bus.ARADDR = 32'h0003_0008; bus.ARVALID = 1'b1;
    step();
    bus.ARVALID = 1'b0;
    check("tout_psel", 64'(bus.PSEL), 64'b1000);
    acc = 0; ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      step();
      if (bus.PSEL[3] && bus.PENABLE) acc++;
      if (bus.RVALID) ok = 1'b1;
    end
    check("tout_rvalid",     64'(ok),        64'd1);
    check("tout_access_cyc", 64'(acc),       64'd16);
    check("tout_rresp",      64'(bus.RRESP), 64'(RESP_SLVERR));
    check("tout_rdata",      64'(bus.RDATA), 64'd0);
    check("tout_psel_off",   64'({bus.PSEL, bus.PENABLE}), 64'd0);
    bus.RREADY = 1'b1;
    step();
    bus.RREADY = 1'b0;

    // Decode boundary: top of slave 3 is valid, next address and 0x8000_0000 are DECERR.
    bus.PREADY = 4'b1111;
    do_read(32'h0003_FFFC, rd_data, rd_resp, sel_cyc, ok);
    check("edge_ok",    64'(ok),      64'd1);
    check("edge_rdata", 64'(rd_data), 64'hFFFF_0000);
    check("edge_rresp", 64'(rd_resp), 64'(RESP_OKAY));
    check("edge_sel",   64'(sel_cyc), 64'd2);
    do_read(32'h0004_0000, rd_data, rd_resp, sel_cyc, ok);
    check("dec4_rresp", 64'({ok, rd_resp}), 64'({1'b1, RESP_DECERR}));
    check("dec4_rdata", 64'(rd_data), 64'd0);
    check("dec4_nosel", 64'(sel_cyc), 64'd0);
    bus.ARADDR = 32'h8000_0000; bus.ARVALID = 1'b1;
    step();
    bus.ARVALID = 1'b0;
    check("dec8_direct", 64'({bus.RVALID, bus.RRESP}), 64'({1'b1, RESP_DECERR}));
    check("dec8_rdata",  64'(bus.RDATA), 64'd0);
    check("dec8_nosel",  64'(bus.PSEL),  64'd0);
    bus.RREADY = 1'b1;
    step();
    bus.RREADY = 1'b0;

    // Asynchronous reset while in ACCESS.
    bus.PREADY = 4'b1101;
    bus.ARADDR = 32'h0001_0020; bus.ARVALID = 1'b1;
    step();
    bus.ARVALID = 1'b0;
    step();
    check("arst_in_access", 64'({bus.PSEL, bus.PENABLE}), 64'b0010_1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_apb_off",  64'({bus.PSEL, bus.PENABLE}), 64'd0);
    check("arst_valids",   64'({bus.RVALID, bus.BVALID}), 64'd0);
    check("arst_readies",  64'({bus.AWREADY, bus.WREADY, bus.ARREADY}), 64'd0);
    step();
    rst_n = 1'b1;
    check("arst_rel_low",  64'(bus.ARREADY), 64'd0);
    step();
    check("arst_rel_high", 64'({bus.AWREADY, bus.WREADY, bus.ARREADY}), 64'b111);

    // Read and write pending together twice: read first after reset, then alternate.
    bus.PREADY = 4'b1111; bus.RREADY = 1'b1; bus.BREADY = 1'b1;
    bus.ARADDR = 32'h0000_0200; bus.ARVALID = 1'b1;
    bus.AWADDR = 32'h0001_0300; bus.AWVALID = 1'b1;
    bus.WDATA = 32'h1111_2222; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
    run_until_idle("arb1", 30);
    bus.ARADDR = 32'h0002_0400; bus.ARVALID = 1'b1;
    bus.AWADDR = 32'h0003_0500; bus.AWVALID = 1'b1;
    bus.WVALID = 1'b1;
    run_until_idle("arb2", 30);
    bus.RREADY = 1'b0; bus.BREADY = 1'b0;
    check("arb_count", 64'(seq_n), 64'd4);
    check("arb_0", 64'({seq_wr[0], seq_addr[0]}), 64'({1'b0, 16'h0200}));
    check("arb_1", 64'({seq_wr[1], seq_addr[1]}), 64'({1'b1, 16'h0300}));
    check("arb_2", 64'({seq_wr[2], seq_addr[2]}), 64'({1'b0, 16'h0400}));
    check("arb_3", 64'({seq_wr[3], seq_addr[3]}), 64'({1'b1, 16'h0500}));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
